// File: rtl/redmule_pkg.sv
// Shared types and helpers for the RedMulE quantised-integer operand path.
package redmule_pkg;

  // Packed operand widths accepted by the unpacker. Other codes fall back to 8 bit.
  typedef enum logic [2:0] {
    QINT_8 = 3'd0,
    QINT_4 = 3'd1,
    QINT_2 = 3'd2,
    QINT_3 = 3'd3
  } qint_fmt_e;

  localparam int unsigned QINT_MAX_BITS = 8;

  // Number of packed bits per element for a format.
  function automatic int unsigned qint_bits(input qint_fmt_e fmt);
    case (fmt)
      QINT_4:  return 4;
      QINT_3:  return 3;
      QINT_2:  return 2;
      default: return 8;
    endcase
  endfunction

  // Map a raw format code onto a supported format; unknown codes become QINT_8.
  function automatic qint_fmt_e qint_norm(input logic [2:0] raw);
    case (raw)
      3'd1:    return QINT_4;
      3'd2:    return QINT_2;
      3'd3:    return QINT_3;
      default: return QINT_8;
    endcase
  endfunction

endpackage

// File: rtl/redmule_qint_expand.sv
// Combinational lane expander: slices q-bit fields from the low end of the
// packed word and widens each one to an ELW-bit lane.
module redmule_qint_expand
  import redmule_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ELW    = 8
) (
  input  logic [DATA_W/ELW*QINT_MAX_BITS-1:0] packed_data,
  input  qint_fmt_e                           fmt,
  input  logic                                sgn,
  output logic [DATA_W-1:0]                   lanes
);

  localparam int unsigned L = DATA_W / ELW;

  int unsigned q;

  // Widen a q-bit field to ELW bits, replicating its top bit when signed.
  function automatic logic [ELW-1:0] ext_lane(input logic [QINT_MAX_BITS-1:0] raw,
                                              input int unsigned qb,
                                              input logic s);
    logic [ELW-1:0] r;
    logic           msb;
    r   = '0;
    msb = raw[3'(qb - 1)];
    for (int b = 0; b < int'(ELW); b++) begin
      r[b] = (32'(b) < qb) ? raw[3'(b)] : (s & msb);
    end
    return r;
  endfunction

  assign q = qint_bits(fmt);

  // Each lane i takes packed bits [i*q +: q]; higher bits of the slice are masked by ext_lane.
  always_comb begin
    lanes = '0;
    for (int i = 0; i < int'(L); i++) begin
      lanes[i*ELW +: ELW] = ext_lane(QINT_MAX_BITS'(packed_data >> (32'(i) * q)), q, sgn);
    end
  end

endmodule

// File: rtl/redmule_qint_unpacker.sv
// Streaming gearbox that turns densely packed QINT_{8,4,3,2} beats into
// ELW-bit lanes. A 2*DATA_W shift buffer absorbs one input beat while the
// previous one is still being unpacked; packed fields may straddle beats.
module redmule_qint_unpacker
  import redmule_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ELW    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [2:0]          fmt_i,
  input  logic                signed_i,
  input  logic                flush_i,
  // packed input stream
  input  logic [DATA_W-1:0]   stream_i_data,
  input  logic [DATA_W/8-1:0] stream_i_strb,
  input  logic                stream_i_valid,
  output logic                stream_i_ready,
  // expanded output stream
  output logic [DATA_W-1:0]   stream_o_data,
  output logic [DATA_W/8-1:0] stream_o_strb,
  output logic                stream_o_valid,
  input  logic                stream_o_ready,
  output logic                empty_o
);

  localparam int unsigned L  = DATA_W / ELW;
  localparam int unsigned BW = 2 * DATA_W;
  localparam int unsigned LW = $clog2(BW + 1);

  logic [BW-1:0] buf_q, buf_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [LW-1:0] n_bits, take;
  logic          flush_q, flush_d;
  qint_fmt_e     fmt_q;
  logic          sgn_q;
  logic          push, pop, load_cfg;
  logic          unused_strb;

  // Only full beats are accepted, so byte strobes carry no information.
  assign unused_strb = ^stream_i_strb;

  // Bits consumed by one full output beat.
  assign n_bits = LW'(L * qint_bits(fmt_q));

  // Input is accepted while one whole beat still fits; a pending flush freezes the input.
  assign stream_i_ready = (lvl_q <= LW'(DATA_W)) && !flush_q;
  assign stream_o_valid = (lvl_q >= n_bits) || (flush_q && (lvl_q != '0));
  assign stream_o_strb  = '1;
  assign empty_o        = (lvl_q == '0) && !flush_q;

  assign push = stream_i_valid && stream_i_ready;
  assign pop  = stream_o_valid && stream_o_ready;

  // Next-state: shift out consumed bits, append the new beat just above the remaining level.
  always_comb begin
    take = '0;
    if (pop) begin
      take = (lvl_q < n_bits) ? lvl_q : n_bits;
    end
    lvl_d = lvl_q - take + (push ? LW'(DATA_W) : '0);
    buf_d = buf_q >> take;
    if (push) begin
      buf_d = buf_d | ({{DATA_W{1'b0}}, stream_i_data} << (lvl_q - take));
    end
    // Flush stays armed until the pop that empties the buffer, including a pad beat.
    flush_d  = (flush_q || (flush_i && (lvl_q != '0))) && (lvl_d != '0);
    load_cfg = (lvl_d == '0) && !flush_q;
  end

  // Buffer, level, flush flag and format registers; clear behaves like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      buf_q   <= '0;
      lvl_q   <= '0;
      flush_q <= 1'b0;
      fmt_q   <= QINT_8;
      sgn_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      lvl_q   <= lvl_d;
      flush_q <= flush_d;
      if (load_cfg) begin
        fmt_q <= qint_norm(fmt_i);
        sgn_q <= signed_i;
      end
    end
  end

  // Bits above lvl_q are always zero in buf_q, so a partial final beat is zero-padded.
  redmule_qint_expand #(
    .DATA_W (DATA_W),
    .ELW    (ELW)
  ) i_expand (
    .packed_data (buf_q[L*QINT_MAX_BITS-1:0]),
    .fmt         (fmt_q),
    .sgn         (sgn_q),
    .lanes       (stream_o_data)
  );

endmodule

// File: tb/tb_redmule_qint_unpacker.sv
// Scoreboard bench for redmule_qint_unpacker with DATA_W=32, ELW=8.
module tb_redmule_qint_unpacker;
  import redmule_pkg::*;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic [2:0]    fmt_i;
  logic          signed_i;
  logic          flush_i;
  logic [DW-1:0] stream_i_data;
  logic [3:0]    stream_i_strb;
  logic          stream_i_valid;
  logic          stream_i_ready;
  logic [DW-1:0] stream_o_data;
  logic [3:0]    stream_o_strb;
  logic          stream_o_valid;
  logic          stream_o_ready;
  logic          empty_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  redmule_qint_unpacker #(.DATA_W(DW), .ELW(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .fmt_i          (fmt_i),
    .signed_i       (signed_i),
    .flush_i        (flush_i),
    .stream_i_data  (stream_i_data),
    .stream_i_strb  (stream_i_strb),
    .stream_i_valid (stream_i_valid),
    .stream_i_ready (stream_i_ready),
    .stream_o_data  (stream_o_data),
    .stream_o_strb  (stream_o_strb),
    .stream_o_valid (stream_o_valid),
    .stream_o_ready (stream_o_ready),
    .empty_o        (empty_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_ni && stream_o_valid && stream_o_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got %h expected none", stream_o_data);
      end else begin
        check("beat", stream_o_data, exp_q.pop_front());
        check("strb", 32'(stream_o_strb), 32'hF);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fmt(input logic [2:0] f, input logic s);
    fmt_i    = f;
    signed_i = s;
    tick();
    tick();
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    stream_i_valid = 1'b1;
    stream_i_data  = w;
    while (!stream_i_ready && n < 100) begin
      tick();
      n++;
    end
    if (!stream_i_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    tick();
    stream_i_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty_o) && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'((exp_q.size() == 0) && empty_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni         = 1'b0;
    clear_i        = 1'b0;
    fmt_i          = QINT_8;
    signed_i       = 1'b0;
    flush_i        = 1'b0;
    stream_i_data  = '0;
    stream_i_strb  = '1;
    stream_i_valid = 1'b0;
    stream_o_ready = 1'b1;
    repeat (3) tick();
    rst_ni = 1'b1;

    // reset state
    check("rst_valid", 32'(stream_o_valid), 32'd0);
    check("rst_ready", 32'(stream_i_ready), 32'd1);
    check("rst_empty", 32'(empty_o), 32'd1);

    // 1: q=8 back-to-back, one beat per cycle, latency one cycle
    set_fmt(QINT_8, 1'b0);
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'h55667788);
    stream_i_valid = 1'b1;
    stream_i_data  = 32'h11223344;
    tick();
    check("q8_latency_valid", 32'(stream_o_valid), 32'd1);
    check("q8_ready_at_full_beat", 32'(stream_i_ready), 32'd1);
    stream_i_data = 32'h55667788;
    tick();
    stream_i_valid = 1'b0;
    check("q8_second_valid", 32'(stream_o_valid), 32'd1);
    drain("q8_drain");

    // 2: q=4 unsigned
    set_fmt(QINT_4, 1'b0);
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    send(32'h87654321);
    drain("q4u_drain");

    // 2b: q=4 with output stalled: second beat fills buffer, input must stall
    stream_o_ready = 1'b0;
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h0C0B0A09);
    exp_q.push_back(32'h000F0E0D);
    send(32'h87654321);
    send(32'h0FEDCBA9);
    check("stall_ready", 32'(stream_i_ready), 32'd0);
    check("stall_valid", 32'(stream_o_valid), 32'd1);
    check("stall_hold_data", stream_o_data, 32'h04030201);
    stream_o_ready = 1'b1;
    drain("stall_drain");

    // 3: q=4 signed
    set_fmt(QINT_4, 1'b1);
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'hF8070605);
    send(32'h87654321);
    drain("q4s_drain");

    // 4: q=3, three words carrying a continuous 0..7 field pattern across straddles
    set_fmt(QINT_3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h03020100);
      exp_q.push_back(32'h07060504);
    end
    send(32'h88FAC688);
    send(32'hC688FAC6);
    send(32'hFAC688FA);
    drain("q3_drain");

    // 5: q=2, flush after the first pop
    set_fmt(QINT_2, 1'b0);
    exp_q.push_back(32'h03020100);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000000);
    send(32'h000000E4);
    tick();
    pulse_flush();
    drain("q2_flush_drain");
    check("q2_empty", 32'(empty_o), 32'd1);

    // 6: q=3 one word then flush: two full beats and a zero-padded residue
    set_fmt(QINT_3, 1'b0);
    exp_q.push_back(32'h03020100);
    exp_q.push_back(32'h07060504);
    exp_q.push_back(32'h00020100);
    send(32'h88FAC688);
    pulse_flush();
    drain("q3_flush_drain");

    // 6b: q=3 signed, residue is all padding
    set_fmt(QINT_3, 1'b1);
    exp_q.push_back(32'h03020100);
    exp_q.push_back(32'hFFFEFDFC);
    exp_q.push_back(32'h00000000);
    send(32'h00FAC688);
    pulse_flush();
    drain("q3s_flush_drain");

    // unsupported format code behaves as QINT_8
    set_fmt(3'd7, 1'b1);
    exp_q.push_back(32'hDEADBEEF);
    send(32'hDEADBEEF);
    drain("badfmt_drain");

    // clear during a pending flush with the output stalled
    set_fmt(QINT_3, 1'b0);
    stream_o_ready = 1'b0;
    send(32'h88FAC688);
    pulse_flush();
    check("pre_clear_valid", 32'(stream_o_valid), 32'd1);
    check("pre_clear_empty", 32'(empty_o), 32'd0);
    check("pre_clear_ready", 32'(stream_i_ready), 32'd0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_valid", 32'(stream_o_valid), 32'd0);
    check("clear_empty", 32'(empty_o), 32'd1);
    check("clear_ready", 32'(stream_i_ready), 32'd1);
    stream_o_ready = 1'b1;
    repeat (5) tick();
    check("post_clear_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
